// File: rtl/display_pkg.sv
// display_pkg: shared state encoding and segment constants for the
// multiplexed 7-segment display driver.
package display_pkg;

   // One-hot scan phases.
   typedef enum logic [2:0] {
      ST_CHARGE = 3'b001,
      ST_SHOW   = 3'b010,
      ST_DISCH  = 3'b100
   } state_e;

   // Active-low segment patterns {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_DARK = 7'h7F;

endpackage : display_pkg

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low 7-segment glyph.
//   nib   in  4  hex value
//   glyph out 7  segments {g,f,e,d,c,b,a}, active low
module hex7seg (
   input  logic [3:0] nib,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = 7'h7F;
      case (nib)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         4'hF: glyph = 7'b0001110;
         default: glyph = 7'h7F;
      endcase
   end

endmodule : hex7seg

// File: rtl/display_mux.sv
// display_mux: time-multiplexed common-anode 7-segment driver.
// Each digit cycles CHARGE -> SHOW -> DISCHARGE; the anode is lit only in SHOW.
// Loaded values sit in a pending set and move to the active set at frame
// boundaries so a frame is never a mix of old and new data.
//   clk, rst_n   clock, async active-low reset
//   d            4*DIGITS hex nibbles, digit 0 rightmost
//   is_d         1 = show d, 0 = dashes
//   dp, blank    per-digit decimal point / blanking
//   lz           leading-zero suppression enable
//   load         strobe capturing d/is_d/dp/blank/lz into the pending set
//   an           anode enables (active low, registered)
//   seg, dp_n    segments / decimal point (active low, combinational)
//   frame_start  pulse in the cycle after digit 0 enters CHARGE
module display_mux
   import display_pkg::*;
#(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned CHARGE_CYC = 1024,
   parameter int unsigned SHOW_CYC   = 14336,
   parameter int unsigned DISCH_CYC  = 1024,
   parameter int unsigned CTR_W      = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   d,
   input  logic                  is_d,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  lz,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic                  frame_start
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_e               state;
   logic [CTR_W-1:0]     ctr;
   logic [IDX_W-1:0]     idx;
   logic                 frame_bnd;

   logic [4*DIGITS-1:0]  act_d,     pend_d;
   logic                 act_is_d,  pend_is_d;
   logic [DIGITS-1:0]    act_dp,    pend_dp;
   logic [DIGITS-1:0]    act_blank, pend_blank;
   logic                 act_lz,    pend_lz;

   logic [DIGITS-1:0]    lead_zero;
   logic                 zrun;
   logic [3:0]           cur_nib;
   logic [6:0]           cur_glyph;
   logic                 suppressed;

   // Wrap from the last digit back to digit 0 at the end of DISCHARGE.
   assign frame_bnd = (state == ST_DISCH) && (ctr == '0) && (idx == LAST_IDX);

   // Scan FSM, phase counter, digit index and anode drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_DISCH;
         ctr         <= '0;
         idx         <= LAST_IDX;
         an          <= '1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_bnd;
         if (ctr != '0) begin
            ctr <= ctr - CTR_W'(1);
         end else begin
            case (state)
               ST_CHARGE: begin
                  state <= ST_SHOW;
                  ctr   <= CTR_W'(SHOW_CYC);
                  an    <= ~(DIGITS'(1) << idx);
               end
               ST_SHOW: begin
                  state <= ST_DISCH;
                  ctr   <= CTR_W'(DISCH_CYC);
                  an    <= '1;
               end
               ST_DISCH: begin
                  state <= ST_CHARGE;
                  ctr   <= CTR_W'(CHARGE_CYC);
                  idx   <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                  an    <= '1;
               end
               default: begin
                  state <= ST_DISCH;
                  ctr   <= '0;
                  an    <= '1;
               end
            endcase
         end
      end
   end

   // Shadow registers: a load on the boundary edge bypasses straight to active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_d     <= '0;
         pend_is_d  <= 1'b0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_lz    <= 1'b0;
         act_d      <= '0;
         act_is_d   <= 1'b0;
         act_dp     <= '0;
         act_blank  <= '0;
         act_lz     <= 1'b0;
      end else begin
         if (load) begin
            pend_d     <= d;
            pend_is_d  <= is_d;
            pend_dp    <= dp;
            pend_blank <= blank;
            pend_lz    <= lz;
         end
         if (frame_bnd) begin
            act_d     <= load ? d     : pend_d;
            act_is_d  <= load ? is_d  : pend_is_d;
            act_dp    <= load ? dp    : pend_dp;
            act_blank <= load ? blank : pend_blank;
            act_lz    <= load ? lz    : pend_lz;
         end
      end
   end

   // lead_zero[k]: nibbles DIGITS-1..k are all zero; digit 0 never qualifies.
   always_comb begin
      lead_zero = '0;
      zrun      = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zrun         = zrun & (act_d[4*i +: 4] == 4'h0);
         lead_zero[i] = zrun;
      end
   end

   assign cur_nib    = act_d[{idx, 2'b00} +: 4];
   assign suppressed = act_lz & act_is_d & lead_zero[idx];

   hex7seg u_hex7seg (
      .nib   (cur_nib),
      .glyph (cur_glyph)
   );

   // Segment priority: blank, then suppression, then dash, then glyph.
   always_comb begin
      seg  = SEG_DARK;
      dp_n = 1'b1;
      if (!act_blank[idx]) begin
         dp_n = ~act_dp[idx];
         if (suppressed) begin
            seg = SEG_DARK;
         end else if (!act_is_d) begin
            seg = SEG_DASH;
         end else begin
            seg = cur_glyph;
         end
      end
   end

endmodule : display_mux

// File: doc/display_mux.md
# display_mux

Parametrised time-multiplexed driver for common-anode 7-segment displays with an arbitrary digit count. It refreshes one digit at a time through a charge / show / discharge cycle with independently configurable phase lengths. New features: per-digit decimal points, per-digit blanking, leading-zero suppression, and tear-free shadow loading, so a value written mid-scan never mixes with the previous frame. It sits between the calculator datapath and the board's anode/segment pins.

## Interface
- `DIGITS`, 4: number of digits (2..8).
- `CHARGE_CYC`, 1024: CHARGE phase reload value.
- `SHOW_CYC`, 14336: SHOW phase reload value.
- `DISCH_CYC`, 1024: DISCHARGE phase reload value.
- `CTR_W`, 14: phase counter width; must hold the largest reload value.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d`  in  4*DIGITS  hex nibbles; digit k = `d[4k+3:4k]`, digit 0 rightmost.
- `is_d`  in  1  1 = show `d`; 0 = every unblanked digit shows '-'.
- `dp`  in  DIGITS  decimal point per digit, 1 = lit.
- `blank`  in  DIGITS  1 = digit fully dark, including DP.
- `lz`  in  1  leading-zero suppression enable.
- `load`  in  1  one-cycle strobe; captures `d`, `is_d`, `dp`, `blank`, `lz` into the pending set.
- `an`  out  DIGITS  anode enables, active low.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active low.
- `dp_n`  out  1  decimal point, active low.
- `frame_start`  out  1  one-cycle pulse when digit 0 enters CHARGE.

## Operation
- The FSM has three states:
  - CHARGE: on `ctr==0` → SHOW; reload `SHOW_CYC`; drive `an[idx]` low and all other anodes high.
  - SHOW: on `ctr==0` → DISCHARGE; reload `DISCH_CYC`; all anodes high.
  - DISCHARGE: on `ctr==0` → CHARGE; reload `CHARGE_CYC`; `idx` advances, wrapping from DIGITS-1 to 0; all anodes high.
- Counter: decrements every cycle when not reloading. Each phase lasts reload+1 cycles.
- Frame boundary: the DISCHARGE→CHARGE transition where `idx` wraps to 0.
- Shadow loading:
  - `load` writes the pending register set.
  - At each frame boundary, active ← pending.
  - If `load` coincides with a frame boundary, the input values go straight to active and to pending.
  - Outputs only ever use the active set.
- Leading-zero suppression: when active `lz`=1 and `is_d`=1, digit k is suppressed (dark, DP still honoured) if nibbles DIGITS-1..k are all zero. Digit 0 is never suppressed.
- Segment priority, highest first: blank → dark (`seg`=7'h7F, `dp_n`=1); suppressed → dark segments; `is_d`=0 → '-' (7'b0111111); otherwise hex glyph of the nibble.
- `seg`/`dp_n` are combinational from active registers and `idx`. Only `an` gates the light.

## Timing
- Reset (async assert) values:
  - state = DISCHARGE, ctr = 0, idx = DIGITS-1.
  - `an` = all 1, `frame_start` = 0.
  - Active and pending sets cleared: `is_d`=0, `dp`=0, `blank`=0, `lz`=0, `d`=0.
  - Hence `seg`=7'b0111111, `dp_n`=1.
- First edge after release: → CHARGE, idx = 0, frame boundary.
- `an[0]` goes low CHARGE_CYC+1 cycles after that edge.
- Per-digit period: CHARGE_CYC+SHOW_CYC+DISCH_CYC+3 cycles (16387 with defaults).
- Frame period: DIGITS × the per-digit period.
- `frame_start`: registered; high in the cycle after the frame-boundary edge.
- Load latency: data loaded mid-frame is visible from the next frame's digit 0 and is never partially applied. Multiple loads within one frame: the last one wins.
- Reset asserted mid-SHOW: `an` goes all-high immediately, asynchronously.

## Structure
- Package `display_pkg` holds:
  - state encodings CHARGE=3'b001, SHOW=3'b010, DISCHARGE=3'b100 (one-hot);
  - the '-' and dark segment constants.
- Sub-module `hex7seg`: combinational 4-bit → 7-bit active-low glyph decoder, the only natural split.
- Top level holds the FSM, counter, digit index, shadow registers and suppression logic.

## Test plan
- Reset release, defaults, DIGITS=4 with small reloads (2,5,2) → `an` sequence 1110,1101,1011,0111 each low 6 cycles, gaps of 6; `seg`=7'b0111111 throughout.
- `load` `d`=16'h00A5, `is_d`=1, `lz`=1 mid-frame → current frame unchanged. Next frame: digits 3,2 dark; digit 1 glyph A (7'b0001000); digit 0 glyph 5 (7'b0010010).
- `load` coincident with the frame-boundary edge → new data shown on digit 0 of that same frame.
- `blank`=4'b0100, `dp`=4'b0101 → digit 2 fully dark with `dp_n`=1; digit 0 has `dp_n`=0.
- `d`=0, `lz`=1 → digit 0 shows '0' (7'b1000000), the others dark.
- Assert `rst_n` during SHOW of digit 2 → `an`=all 1 in the same cycle; after release the scan restarts at digit 0 with `frame_start` high one cycle later.
